// File: rtl/mask_bbox_pkg.sv
// Shared widths, accumulator record and FSM encoding for the mask bounding-box tracker.
package mask_bbox_pkg;

  localparam int BBOX_XW = 11;
  localparam int BBOX_YW = 11;
  localparam int BBOX_CW = 21;

  typedef struct packed {
    logic [BBOX_XW-1:0] x_min;
    logic [BBOX_XW-1:0] x_max;
    logic [BBOX_YW-1:0] y_min;
    logic [BBOX_YW-1:0] y_max;
    logic [BBOX_CW-1:0] cnt;
  } bbox_t;

  typedef enum logic [0:0] {
    WAIT_SYNC = 1'b0,
    ACTIVE    = 1'b1
  } fsm_e;

  // min fields start at all-ones so the first mask pixel always wins the compare
  localparam bbox_t BBOX_INIT = '{x_min: '1, x_max: '0, y_min: '1, y_max: '0, cnt: '0};

endpackage

// File: rtl/mask_bbox_pix_coord_gen.sv
// Pixel coordinate generator: de/vs edge detection, saturating x/y counters, vs-rise strobe.
module pix_coord_gen #(
  parameter int XW = 11,
  parameter int YW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_de_i,
  input  logic          in_vs_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          vs_rise_o
);

  logic          de_q, vs_q;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          de_fall;

  assign vs_rise_o = in_vs_i & ~vs_q;
  assign de_fall   = ~in_de_i & de_q;
  assign x_o       = x_q;
  assign y_o       = y_q;

  always_comb begin
    x_d = x_q;
    if (in_de_i) begin
      if (x_q != '1) x_d = x_q + 1'b1;
    end else if (de_fall) begin
      x_d = '0;
    end

    y_d = y_q;
    if (vs_rise_o) begin
      y_d = '0;
    end else if (de_fall && (y_q != '1)) begin
      y_d = y_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_q <= 1'b0;
      vs_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      de_q <= in_de_i;
      vs_q <= in_vs_i;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

endmodule

// File: rtl/mask_bbox.sv
// Per-frame bounding box / pixel count of a 1-bit mask, latched at each vsync rise.
// Optional MASK_BBOX_SUM_EN adds latched x/y coordinate sums for centroid computation.
// XW/YW/CW must match the package widths since accumulators use bbox_t.
//   state     | meaning
//   WAIT_SYNC | after reset, discarding the partial frame until the first vs rise
//   ACTIVE    | accumulating; each vs rise reports the closing frame
module mask_bbox
  import mask_bbox_pkg::*;
#(
  parameter int XW         = BBOX_XW,
  parameter int YW         = BBOX_YW,
  parameter int CW         = BBOX_CW,
  parameter int MIN_PIXELS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_data,
  input  logic          in_de,
  input  logic          in_hs,
  input  logic          in_vs,
  output logic [XW-1:0] box_x_min,
  output logic [XW-1:0] box_x_max,
  output logic [YW-1:0] box_y_min,
  output logic [YW-1:0] box_y_max,
  output logic [CW-1:0] pix_cnt,
  output logic          obj_found,
`ifdef MASK_BBOX_SUM_EN
  output logic [XW+CW-1:0] sum_x,
  output logic [YW+CW-1:0] sum_y,
`endif
  output logic          frame_valid
);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          vs_rise;
  logic          hit;
  logic          unused_hs;

  fsm_e  state_q, state_d;
  bbox_t acc_q, acc_d, out_q, out_d;
  logic  obj_q, obj_d, fv_q, fv_d;

  assign unused_hs = in_hs;
  assign hit       = in_de & in_data;

  pix_coord_gen #(.XW(XW), .YW(YW)) u_coord (
    .clk       (clk),
    .rst       (rst),
    .in_de_i   (in_de),
    .in_vs_i   (in_vs),
    .x_o       (x),
    .y_o       (y),
    .vs_rise_o (vs_rise)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    out_d   = out_q;
    obj_d   = obj_q;
    fv_d    = 1'b0;
    if (vs_rise) begin
      // a pixel coinciding with vs rise belongs to neither frame
      acc_d   = BBOX_INIT;
      state_d = ACTIVE;
      if (state_q == ACTIVE) begin
        fv_d  = 1'b1;
        out_d = '0;
        if (acc_q.cnt != '0) out_d = acc_q;
        obj_d = (acc_q.cnt >= CW'(MIN_PIXELS));
      end
    end else if ((state_q == ACTIVE) && hit) begin
      if (x < acc_q.x_min) acc_d.x_min = x;
      if (x > acc_q.x_max) acc_d.x_max = x;
      if (y < acc_q.y_min) acc_d.y_min = y;
      if (y > acc_q.y_max) acc_d.y_max = y;
      if (acc_q.cnt != '1) acc_d.cnt = acc_q.cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_SYNC;
      acc_q   <= BBOX_INIT;
      out_q   <= '0;
      obj_q   <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      obj_q   <= obj_d;
      fv_q    <= fv_d;
    end
  end

  assign box_x_min   = out_q.x_min;
  assign box_x_max   = out_q.x_max;
  assign box_y_min   = out_q.y_min;
  assign box_y_max   = out_q.y_max;
  assign pix_cnt     = out_q.cnt;
  assign obj_found   = obj_q;
  assign frame_valid = fv_q;

`ifdef MASK_BBOX_SUM_EN
  logic [XW+CW-1:0] sx_acc_q, sx_acc_d, sx_out_q, sx_out_d;
  logic [YW+CW-1:0] sy_acc_q, sy_acc_d, sy_out_q, sy_out_d;
  logic [XW+CW:0]   sx_add;
  logic [YW+CW:0]   sy_add;

  assign sx_add = {1'b0, sx_acc_q} + (XW+CW+1)'(x);
  assign sy_add = {1'b0, sy_acc_q} + (YW+CW+1)'(y);

  always_comb begin
    sx_acc_d = sx_acc_q;
    sy_acc_d = sy_acc_q;
    sx_out_d = sx_out_q;
    sy_out_d = sy_out_q;
    if (vs_rise) begin
      sx_acc_d = '0;
      sy_acc_d = '0;
      if (state_q == ACTIVE) begin
        sx_out_d = (acc_q.cnt != '0) ? sx_acc_q : '0;
        sy_out_d = (acc_q.cnt != '0) ? sy_acc_q : '0;
      end
    end else if ((state_q == ACTIVE) && hit) begin
      sx_acc_d = sx_add[XW+CW] ? '1 : sx_add[XW+CW-1:0];
      sy_acc_d = sy_add[YW+CW] ? '1 : sy_add[YW+CW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx_acc_q <= '0;
      sy_acc_q <= '0;
      sx_out_q <= '0;
      sy_out_q <= '0;
    end else begin
      sx_acc_q <= sx_acc_d;
      sy_acc_q <= sy_acc_d;
      sx_out_q <= sx_out_d;
      sy_out_q <= sy_out_d;
    end
  end

  assign sum_x = sx_out_q;
  assign sum_y = sy_out_q;
`endif

endmodule

// File: tb/tb_mask_bbox.sv
// Directed bench for mask_bbox: 16x8 frames with rectangle/point masks and hand-computed reports.
module tb_mask_bbox;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_data = 1'b0, in_de = 1'b0, in_hs = 1'b0, in_vs = 1'b0;
  logic [10:0] box_x_min, box_x_max, box_y_min, box_y_max;
  logic [20:0] pix_cnt;
  logic        obj_found, frame_valid;
`ifdef MASK_BBOX_SUM_EN
  logic [31:0] sum_x, sum_y;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit pts_mode = 1'b0;
  bit sum_chk = 1'b0;
  int esx = 0, esy = 0;

  mask_bbox dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_de       (in_de),
    .in_hs       (in_hs),
    .in_vs       (in_vs),
    .box_x_min   (box_x_min),
    .box_x_max   (box_x_max),
    .box_y_min   (box_y_min),
    .box_y_max   (box_y_max),
    .pix_cnt     (pix_cnt),
    .obj_found   (obj_found),
`ifdef MASK_BBOX_SUM_EN
    .sum_x       (sum_x),
    .sum_y       (sum_y),
`endif
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic vs, input logic de, input logic data);
    in_vs   = vs;
    in_de   = de;
    in_data = data;
    @(posedge clk);
    #1;
  endtask

  function automatic logic mask(input int x, input int y, input int bx0, input int bx1,
                                input int by0, input int by1);
    if (pts_mode) return ((x == 2 && y == 1) || (x == 4 && y == 3));
    return (x >= bx0 && x <= bx1 && y >= by0 && y <= by1);
  endfunction

  task automatic check_report(input int ex0, input int ex1, input int ey0, input int ey1,
                              input int ecnt, input bit eobj);
    chk("fv_pulse", 64'(frame_valid), 64'd1);
    chk("x_min", 64'(box_x_min), 64'(ex0));
    chk("x_max", 64'(box_x_max), 64'(ex1));
    chk("y_min", 64'(box_y_min), 64'(ey0));
    chk("y_max", 64'(box_y_max), 64'(ey1));
    chk("pix_cnt", 64'(pix_cnt), 64'(ecnt));
    chk("obj_found", 64'(obj_found), 64'(eobj));
`ifdef MASK_BBOX_SUM_EN
    if (sum_chk) begin
      chk("sum_x", 64'(sum_x), 64'(esx));
      chk("sum_y", 64'(sum_y), 64'(esy));
    end
`endif
  endtask

  // vs high 2 cycles, 1 blank, then 8 lines of 16 de cycles + 2 blank cycles
  task automatic frame(input bit rep, input bit de_at_vs,
                       input int ex0, input int ex1, input int ey0, input int ey1,
                       input int ecnt, input bit eobj,
                       input int bx0, input int bx1, input int by0, input int by1);
    int fvc;
    cyc(1'b1, de_at_vs, de_at_vs);
    if (rep) check_report(ex0, ex1, ey0, ey1, ecnt, eobj);
    else chk("fv_none", 64'(frame_valid), 64'd0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("fv_width", 64'(frame_valid), 64'd0);
    cyc(1'b0, 1'b0, 1'b0);
    fvc = 0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 16; x++) begin
        cyc(1'b0, 1'b1, mask(x, y, bx0, bx1, by0, by1));
        fvc += int'(frame_valid);
      end
      cyc(1'b0, 1'b0, 1'b0);
      fvc += int'(frame_valid);
      cyc(1'b0, 1'b0, 1'b0);
      fvc += int'(frame_valid);
    end
    chk("fv_in_body", 64'(fvc), 64'd0);
    chk("hold_cnt", 64'(pix_cnt), rep ? 64'(ecnt) : 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fv", 64'(frame_valid), 64'd0);
    chk("rst_x_min", 64'(box_x_min), 64'd0);
    chk("rst_cnt", 64'(pix_cnt), 64'd0);
    chk("rst_obj", 64'(obj_found), 64'd0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);

    // rectangle x=3..5, y=2..4 (9 pixels), then full frame, then empty
    frame(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 3, 5, 2, 4);
    frame(1'b1, 1'b0, 3, 5, 2, 4, 9, 1'b0, 3, 5, 2, 4);
    frame(1'b1, 1'b0, 3, 5, 2, 4, 9, 1'b0, 0, 15, 0, 7);
    frame(1'b1, 1'b0, 0, 15, 0, 7, 128, 1'b1, 1, 0, 1, 0);
    sum_chk = 1'b1; esx = 0; esy = 0;
    // empty report while a mask pixel coincides with vs rise
    frame(1'b1, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1, 0, 1, 0);
    frame(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0, 0, 3, 0, 3);
    sum_chk = 1'b0;
    // MIN_PIXELS boundary: 16 then 15 pixels
    frame(1'b1, 1'b0, 0, 3, 0, 3, 16, 1'b1, 0, 4, 0, 2);
    pts_mode = 1'b1;
    frame(1'b1, 1'b0, 0, 4, 0, 2, 15, 1'b0, 0, 0, 0, 0);
    pts_mode = 1'b0;
    sum_chk = 1'b1; esx = 6; esy = 4;
    frame(1'b1, 1'b0, 2, 4, 1, 3, 2, 1'b0, 3, 5, 2, 4);
    sum_chk = 1'b0;

    // mid-frame reset after 5 mask pixels
    cyc(1'b1, 1'b0, 1'b0);
    check_report(3, 5, 2, 4, 9, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int x = 0; x < 16; x++) cyc(1'b0, 1'b1, (x < 5) ? 1'b1 : 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_cnt", 64'(pix_cnt), 64'd0);
    chk("mid_rst_x_max", 64'(box_x_max), 64'd0);
    chk("mid_rst_y_min", 64'(box_y_min), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) cyc(1'b0, (i < 16) ? 1'b1 : 1'b0, 1'b1);
    frame(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 1, 2, 1, 1);
    frame(1'b1, 1'b0, 1, 2, 1, 1, 2, 1'b0, 1, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
